// File: rtl/nonogram_option_store_ctrl.sv
// nonogram_option_store_ctrl: packs parser line options sequentially into an external
// single-port option RAM, keeps a per-line base/count directory, and streams one line's
// options back per solver request once the board is loaded.
// Optional macro OPTSTORE_STATS_EN adds the total_opts / max_opts statistics outputs.
module nonogram_option_store_ctrl #(
  parameter int unsigned LINE_W    = 16,
  parameter int unsigned MAX_LINES = 22,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned CNT_W     = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              write_ready,
  input  logic [LINE_W-1:0] line,
  input  logic              line_end,
  input  logic              board_done,
  input  logic              rd_req,
  input  logic [4:0]        rd_line,
  output logic [LINE_W-1:0] opt_out,
  output logic              opt_valid,
  output logic              opt_last,
  output logic              rd_done,
  output logic              rd_busy,
  output logic              board_loaded,
  output logic              overflow,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
`ifdef OPTSTORE_STATS_EN
  output logic [ADDR_W-1:0] total_opts,
  output logic [CNT_W-1:0]  max_opts,
`endif
  input  logic [LINE_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {StLoad, StReady, StIssue, StDrain} state_e;

  localparam logic [4:0] LineLimit = 5'(MAX_LINES);

  state_e            state_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic              full_q;      // last RAM location has been written
  logic [4:0]        line_idx_q;  // saturates at MAX_LINES
  logic [ADDR_W-1:0] base_q [MAX_LINES];
  logic [CNT_W-1:0]  cnt_q  [MAX_LINES];
  logic [CNT_W-1:0]  rd_cnt_q;
  logic [CNT_W-1:0]  issued_q;    // addresses issued so far, including the current one
  logic              opt_valid_q, opt_last_q, rd_done_q, rd_busy_q;
  logic              board_loaded_q, overflow_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [LINE_W-1:0] mem_wdata_q;
`ifdef OPTSTORE_STATS_EN
  logic [CNT_W-1:0]  max_opts_q;
`endif

  logic              line_ok, rd_ok, wr_accept, wr_drop;
  logic [CNT_W-1:0]  cur_cnt, sel_cnt;
  logic [ADDR_W-1:0] sel_base;

  // Decode the current write target and the directory entry of the requested read line.
  always_comb begin
    line_ok  = line_idx_q < LineLimit;
    cur_cnt  = '0;
    if (line_ok) cur_cnt = cnt_q[line_idx_q];
    wr_accept = (state_q == StLoad) && write_ready && line_ok && !full_q && (cur_cnt != '1);
    wr_drop   = (state_q == StLoad) && write_ready && !wr_accept;
    rd_ok     = rd_line < LineLimit;
    sel_cnt   = '0;
    sel_base  = '0;
    if (rd_ok) begin
      sel_cnt  = cnt_q[rd_line];
      sel_base = base_q[rd_line];
    end
  end

  // Single FSM: load-phase capture, directory upkeep, and read-phase streaming.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StLoad;
      wr_ptr_q       <= '0;
      full_q         <= 1'b0;
      line_idx_q     <= '0;
      for (int unsigned i = 0; i < MAX_LINES; i++) begin
        base_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      rd_cnt_q       <= '0;
      issued_q       <= '0;
      opt_valid_q    <= 1'b0;
      opt_last_q     <= 1'b0;
      rd_done_q      <= 1'b0;
      rd_busy_q      <= 1'b0;
      board_loaded_q <= 1'b0;
      overflow_q     <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
`ifdef OPTSTORE_STATS_EN
      max_opts_q     <= '0;
`endif
    end else if (clear) begin
      // RAM contents and bases stay; counts of zero make stale bases harmless.
      state_q        <= StLoad;
      wr_ptr_q       <= '0;
      full_q         <= 1'b0;
      line_idx_q     <= '0;
      for (int unsigned i = 0; i < MAX_LINES; i++) cnt_q[i] <= '0;
      opt_valid_q    <= 1'b0;
      opt_last_q     <= 1'b0;
      rd_done_q      <= 1'b0;
      rd_busy_q      <= 1'b0;
      board_loaded_q <= 1'b0;
      overflow_q     <= 1'b0;
      mem_we_q       <= 1'b0;
`ifdef OPTSTORE_STATS_EN
      max_opts_q     <= '0;
`endif
    end else begin
      mem_we_q  <= 1'b0;
      rd_done_q <= 1'b0;
      unique case (state_q)
        StLoad: begin
          // An empty line keeps tracking wr_ptr, so its base is fixed by its first write.
          if (line_ok && (cur_cnt == '0)) base_q[line_idx_q] <= wr_ptr_q;
          if (wr_accept) begin
            mem_we_q            <= 1'b1;
            mem_addr_q          <= wr_ptr_q;
            mem_wdata_q         <= line;
            wr_ptr_q            <= wr_ptr_q + 1'b1;
            cnt_q[line_idx_q]   <= cur_cnt + 1'b1;
            if (wr_ptr_q == '1) full_q <= 1'b1;
`ifdef OPTSTORE_STATS_EN
            if ((cur_cnt + 1'b1) > max_opts_q) max_opts_q <= cur_cnt + 1'b1;
`endif
          end
          if (wr_drop) overflow_q <= 1'b1;
          if (line_end && line_ok) line_idx_q <= line_idx_q + 1'b1;
          if (board_done) state_q <= StReady;
        end
        StReady: begin
          board_loaded_q <= 1'b1;
          rd_busy_q      <= 1'b0;
          if (rd_req && !rd_busy_q) begin
            rd_busy_q <= 1'b1;
            rd_cnt_q  <= sel_cnt;
            if (sel_cnt == '0) begin
              // Invalid or empty line: finish immediately without data.
              rd_done_q <= 1'b1;
            end else begin
              mem_addr_q <= sel_base;
              issued_q   <= CNT_W'(1);
              state_q    <= StIssue;
            end
          end
        end
        StIssue: begin
          // Data for the address on the bus this cycle appears on mem_rdata next cycle.
          opt_valid_q <= 1'b1;
          if (issued_q == rd_cnt_q) begin
            opt_last_q <= 1'b1;
            rd_done_q  <= 1'b1;
            state_q    <= StDrain;
          end else begin
            mem_addr_q <= mem_addr_q + 1'b1;
            issued_q   <= issued_q + 1'b1;
          end
        end
        StDrain: begin
          opt_valid_q <= 1'b0;
          opt_last_q  <= 1'b0;
          rd_busy_q   <= 1'b0;
          state_q     <= StReady;
        end
      endcase
    end
  end

  assign opt_out      = opt_valid_q ? mem_rdata : '0;
  assign opt_valid    = opt_valid_q;
  assign opt_last     = opt_last_q;
  assign rd_done      = rd_done_q;
  assign rd_busy      = rd_busy_q;
  assign board_loaded = board_loaded_q;
  assign overflow     = overflow_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
`ifdef OPTSTORE_STATS_EN
  assign total_opts   = wr_ptr_q;
  assign max_opts     = max_opts_q;
`endif

endmodule

// File: tb/tb_nonogram_option_store_ctrl.sv
// Self-checking bench for nonogram_option_store_ctrl: scripted and randomized boards are
// loaded, mirrored in a behavioural option-list model, and read back with cycle checks.
module tb_nonogram_option_store_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0, write_ready = 1'b0, line_end = 1'b0, board_done = 1'b0;
  logic        rd_req = 1'b0;
  logic [15:0] line = '0;
  logic [4:0]  rd_line = '0;
  logic [15:0] opt_out, mem_wdata, mem_rdata;
  logic        opt_valid, opt_last, rd_done, rd_busy, board_loaded, overflow, mem_we;
  logic [9:0]  mem_addr;

  logic [15:0] ram [1024];
  int total = 0;
  int bad = 0;

  // Model: accepted options in arrival order, per-line option counts.
  logic [15:0] m_vals [1024];
  int          m_cnt [22];
  int          m_ptr, m_line;
  bit          m_ovf;

  nonogram_option_store_ctrl dut (
    .clk(clk), .rst(rst), .clear(clear), .write_ready(write_ready), .line(line),
    .line_end(line_end), .board_done(board_done), .rd_req(rd_req), .rd_line(rd_line),
    .opt_out(opt_out), .opt_valid(opt_valid), .opt_last(opt_last), .rd_done(rd_done),
    .rd_busy(rd_busy), .board_loaded(board_loaded), .overflow(overflow), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port RAM with one cycle read latency.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_ptr = 0;
    m_line = 0;
    m_ovf = 1'b0;
    for (int i = 0; i < 22; i++) m_cnt[i] = 0;
  endtask

  task automatic clear_all();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_clear();
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL clear_ovf: got %b want 0", overflow); end
    total++; if (board_loaded !== 1'b0) begin bad++; $display("FAIL clear_loaded: got %b want 0", board_loaded); end
  endtask

  // One option from the parser, optionally closing the line in the same cycle.
  task automatic put_opt(input logic [15:0] v, input bit with_end);
    bit acc;
    acc = 1'b0;
    if (m_line < 22) acc = (m_ptr < 1024) && (m_cnt[m_line] < 127);
    write_ready = 1'b1;
    line = v;
    line_end = with_end;
    tick();
    write_ready = 1'b0;
    line_end = 1'b0;
    if (acc) begin
      total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL wr_we: got %b want 1", mem_we); end
      total++; if (mem_addr !== 10'(m_ptr)) begin bad++; $display("FAIL wr_addr: got %0d want %0d", mem_addr, m_ptr); end
      total++; if (mem_wdata !== v) begin bad++; $display("FAIL wr_data: got %h want %h", mem_wdata, v); end
      m_vals[m_ptr] = v;
      m_ptr++;
      m_cnt[m_line]++;
    end else begin
      m_ovf = 1'b1;
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL drop_we: got %b want 0", mem_we); end
    end
    if (with_end && m_line < 22) m_line++;
    total++; if (overflow !== m_ovf) begin bad++; $display("FAIL ovf_flag: got %b want %b", overflow, m_ovf); end
  endtask

  task automatic end_line();
    line_end = 1'b1;
    tick();
    line_end = 1'b0;
    if (m_line < 22) m_line++;
  endtask

  task automatic finish_board();
    board_done = 1'b1;
    tick();
    board_done = 1'b0;
    total++; if (board_loaded !== 1'b0) begin bad++; $display("FAIL loaded_early: got %b want 0", board_loaded); end
    tick();
    total++; if (board_loaded !== 1'b1) begin bad++; $display("FAIL loaded: got %b want 1", board_loaded); end
  endtask

  // Request one line and check the whole read transaction cycle by cycle.
  task automatic read_line(input int ln);
    int n, b;
    n = 0;
    if (ln < 22) n = m_cnt[ln];
    b = 0;
    for (int i = 0; i < ln && i < 22; i++) b += m_cnt[i];
    rd_req = 1'b1;
    rd_line = 5'(ln);
    tick();
    if (n == 0) begin
      rd_req = 1'($urandom_range(0, 1));  // must be ignored while busy
      rd_line = 5'($urandom_range(0, 21));
      total++; if (rd_done !== 1'b1) begin bad++; $display("FAIL empty_done: line %0d got %b want 1", ln, rd_done); end
      total++; if (rd_busy !== 1'b1) begin bad++; $display("FAIL empty_busy: got %b want 1", rd_busy); end
      total++; if (opt_valid !== 1'b0) begin bad++; $display("FAIL empty_valid: got %b want 0", opt_valid); end
      tick();
      rd_req = 1'b0;
    end else begin
      for (int c = 1; c <= n + 1; c++) begin
        rd_req = (c <= n) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (c <= n) begin
          total++; if (mem_addr !== 10'(b + c - 1)) begin bad++; $display("FAIL rd_addr: c=%0d got %0d want %0d", c, mem_addr, b + c - 1); end
          total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rd_we: got %b want 0", mem_we); end
        end
        total++; if (opt_valid !== (c >= 2)) begin bad++; $display("FAIL rd_valid: c=%0d got %b want %b", c, opt_valid, c >= 2); end
        if (c >= 2) begin
          total++; if (opt_out !== m_vals[b + c - 2]) begin bad++; $display("FAIL rd_data: line %0d k=%0d got %h want %h", ln, c - 2, opt_out, m_vals[b + c - 2]); end
        end
        total++; if (opt_last !== (c == n + 1)) begin bad++; $display("FAIL rd_last: c=%0d got %b", c, opt_last); end
        total++; if (rd_done !== (c == n + 1)) begin bad++; $display("FAIL rd_done: c=%0d got %b", c, rd_done); end
        total++; if (rd_busy !== 1'b1) begin bad++; $display("FAIL rd_busy: c=%0d got %b want 1", c, rd_busy); end
        tick();
      end
    end
    total++; if (rd_busy !== 1'b0) begin bad++; $display("FAIL rd_idle_busy: got %b want 0", rd_busy); end
    total++; if (opt_valid !== 1'b0) begin bad++; $display("FAIL rd_idle_valid: got %b want 0", opt_valid); end
    total++; if (rd_done !== 1'b0) begin bad++; $display("FAIL rd_idle_done: got %b want 0", rd_done); end
  endtask

  task automatic test_reset();
    logic [48:0] obs;
    model_clear();
    #23;
    obs = {opt_out, opt_valid, opt_last, rd_done, rd_busy, board_loaded, overflow, mem_we,
           mem_addr, mem_wdata};
    total++; if (obs !== '0) begin bad++; $display("FAIL reset_outs: got %h want 0", obs); end
    rst = 1'b1;
    tick();
    obs = {opt_out, opt_valid, opt_last, rd_done, rd_busy, board_loaded, overflow, mem_we,
           mem_addr, mem_wdata};
    total++; if (obs !== '0) begin bad++; $display("FAIL post_reset_outs: got %h want 0", obs); end
  endtask

  task automatic test_rd_in_load();
    clear_all();
    rd_req = 1'b1;
    rd_line = 5'd0;
    tick();
    tick();
    rd_req = 1'b0;
    total++; if (rd_busy !== 1'b0) begin bad++; $display("FAIL load_rd_busy: got %b want 0", rd_busy); end
    total++; if (rd_done !== 1'b0) begin bad++; $display("FAIL load_rd_done: got %b want 0", rd_done); end
  endtask

  task automatic test_board_4x4();
    clear_all();
    put_opt(16'b1111, 1'b0); end_line();
    put_opt(16'b0110, 1'b0); put_opt(16'b1001, 1'b0); end_line();
    put_opt(16'($urandom), 1'b0); put_opt(16'($urandom), 1'b0); end_line();
    put_opt(16'($urandom), 1'b0); end_line();
    end_line();  // line 4 closed with no options
    finish_board();
    read_line(1);
    read_line(0);
    read_line(2);
    read_line(3);
    read_line(4);
    read_line(30);
  endtask

  task automatic test_same_cycle();
    clear_all();
    put_opt(16'hA5A5, 1'b1);
    put_opt(16'h1234, 1'b0);
    put_opt(16'h00FF, 1'b1);
    finish_board();
    total++; if (m_cnt[0] != 1 || m_cnt[1] != 2) begin bad++; $display("FAIL same_model: %0d %0d", m_cnt[0], m_cnt[1]); end
    read_line(0);
    read_line(1);
    read_line(2);
  endtask

  task automatic test_random_board();
    for (int rep = 0; rep < 3; rep++) begin
      int nl;
      clear_all();
      nl = $urandom_range(3, 22);
      for (int l = 0; l < nl; l++) begin
        int cnt;
        bit merged;
        cnt = $urandom_range(0, 6);
        merged = 1'b0;
        for (int k = 0; k < cnt; k++) begin
          merged = (k == cnt - 1) && ($urandom_range(0, 1) == 1);
          put_opt(16'($urandom), merged);
          if ($urandom_range(0, 3) == 0) tick();
        end
        if (!merged) end_line();
      end
      finish_board();
      for (int l = 0; l <= nl && l < 22; l++) read_line(l);
      for (int r = 0; r < 4; r++) read_line($urandom_range(0, 31));
    end
  endtask

  task automatic test_overflow();
    // Count saturation at 127 on one line.
    clear_all();
    for (int k = 0; k < 128; k++) put_opt(16'($urandom), 1'b0);
    // Line index beyond the directory.
    clear_all();
    for (int l = 0; l < 23; l++) end_line();
    put_opt(16'hBEEF, 1'b0);
    // RAM full: 1024 accepted, 1025th dropped.
    clear_all();
    for (int l = 0; l < 8; l++) begin
      for (int k = 0; k < 120; k++) put_opt(16'($urandom), 1'b0);
      end_line();
    end
    for (int k = 0; k < 64; k++) put_opt(16'($urandom), 1'b0);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL full_ovf_early: got %b want 0", overflow); end
    put_opt(16'hDEAD, 1'b0);
    tick(); tick(); tick();
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL full_ovf_sticky: got %b want 1", overflow); end
    end_line();
    finish_board();
    read_line(8);
    read_line(7);
    clear_all();
    rd_req = 1'b1;
    rd_line = 5'd0;
    tick();
    rd_req = 1'b0;
    total++; if (rd_busy !== 1'b0) begin bad++; $display("FAIL clr_rd_busy: got %b want 0", rd_busy); end
  endtask

  task automatic test_reset_mid_drain();
    logic [48:0] obs;
    int guard;
    clear_all();
    for (int k = 0; k < 5; k++) put_opt(16'($urandom), 1'b0);
    end_line();
    finish_board();
    rd_req = 1'b1;
    rd_line = 5'd0;
    tick();
    rd_req = 1'b0;
    guard = 0;
    while (opt_valid !== 1'b1 && guard < 10) begin
      tick();
      guard++;
    end
    total++; if (opt_valid !== 1'b1) begin bad++; $display("FAIL drain_wait: got %b want 1", opt_valid); end
    rst = 1'b0;
    #2;
    obs = {opt_out, opt_valid, opt_last, rd_done, rd_busy, board_loaded, overflow, mem_we,
           mem_addr, mem_wdata};
    total++; if (obs !== '0) begin bad++; $display("FAIL async_reset_outs: got %h want 0", obs); end
    #2;
    rst = 1'b1;
    model_clear();
    tick();
    rd_req = 1'b1;
    rd_line = 5'd0;
    tick();
    tick();
    rd_req = 1'b0;
    total++; if (rd_busy !== 1'b0) begin bad++; $display("FAIL post_rst_busy: got %b want 0", rd_busy); end
    total++; if (rd_done !== 1'b0) begin bad++; $display("FAIL post_rst_done: got %b want 0", rd_done); end
    total++; if (board_loaded !== 1'b0) begin bad++; $display("FAIL post_rst_loaded: got %b want 0", board_loaded); end
    finish_board();
    read_line(0);
  endtask

  initial begin
    test_reset();
    test_rd_in_load();
    test_board_4x4();
    test_same_cycle();
    test_random_board();
    test_overflow();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nonogram_option_store_ctrl.md
Name: nonogram_option_store_ctrl

Overview:
- Sits between the clue parser and the line solver.
- Captures the stream of candidate line options the parser emits (line, write_ready, per-line boundaries) into an external single-port option RAM, packed sequentially.
- Builds a per-line base/count directory; after board_done, serves solver requests by streaming one line's options back out of the same RAM.
- Arbitrates the single RAM port between the load phase and the read phase.

Parameters:
- LINE_W, 16, width of one line option bitmap.
- MAX_LINES, 22, directory entries (rows then columns, 11x11 max board).
- ADDR_W, 10, option RAM address width (1024 options).
- CNT_W, 7, per-line option count width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- clear  in  1  pulse; restart load phase
- write_ready  in  1  parser option valid
- line  in  LINE_W  parser option bitmap
- line_end  in  1  pulse; current line's option list is complete
- board_done  in  1  parser finished whole board
- rd_req  in  1  solver read request
- rd_line  in  5  line index to read
- opt_out  out  LINE_W  streamed option
- opt_valid  out  1  opt_out valid
- opt_last  out  1  final option of the requested line
- rd_done  out  1  one-cycle pulse ending every accepted read
- rd_busy  out  1  read in progress
- board_loaded  out  1  directory valid, reads allowed
- overflow  out  1  sticky; RAM full or line index > MAX_LINES-1
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  LINE_W  RAM write data
- mem_rdata  in  LINE_W  RAM read data, 1-cycle latency

Behaviour:
- Reset (rst=0, asynchronous):
  - State LOAD.
  - All outputs 0; wr_ptr=0, line_idx=0.
  - Directory counts 0.
- States: LOAD, READY, ISSUE, DRAIN.
- LOAD, write_ready=1 (registered path):
  - Next cycle: mem_we=1, mem_addr=wr_ptr, mem_wdata=line.
  - wr_ptr and count[line_idx] increment; base[line_idx] is the wr_ptr value at the line's first write.
- LOAD, line_end=1:
  - line_idx increments.
  - If write_ready is asserted in the same cycle, that option belongs to the closing line.
  - line_end with no writes leaves count=0, base=wr_ptr.
- Overflow:
  - A write with wr_ptr = 2^ADDR_W-1 already used, or with line_idx >= MAX_LINES, is dropped and sets overflow.
  - count saturates at 2^CNT_W-1; further writes to that line are dropped and set overflow.
- LOAD, board_done=1:
  - A write_ready/line_end in the same cycle is still captured.
  - Next state READY; board_loaded=1 the following cycle.
- READY:
  - write_ready/line_end are ignored.
  - rd_req=1 in cycle T latches rd_line, base, count.
  - rd_line >= MAX_LINES: rd_done at T+1, no data.
- ISSUE:
  - mem_addr = base+k for k=0..count-1, one per cycle from T+1.
  - mem_we=0 throughout.
- DRAIN:
  - opt_out = mem_rdata, opt_valid=1 from T+2, consecutive cycles.
  - opt_last and rd_done on the final option.
  - Then READY.
- count=0: rd_done at T+1, no opt_valid, back to READY.
- rd_busy: 1 from T+1 through the rd_done cycle.
- rd_req while busy is ignored; the solver must wait for rd_done.
- rd_req in LOAD is ignored.
- clear (any state, synchronous):
  - Next state LOAD; wr_ptr, line_idx, counts, overflow, board_loaded cleared.
  - An in-flight read aborts with no rd_done.
  - RAM contents are not erased.
- Address arithmetic is modulo 2^ADDR_W only for base+k, which cannot wrap because base+count <= wr_ptr.

Optional Feature:
- Macro OPTSTORE_STATS_EN, when defined, adds outputs:
  - total_opts [ADDR_W], equal to wr_ptr.
  - max_opts [CNT_W], the largest count in the directory, updated on every accepted write.
  - Both clear on reset and clear.
- Undefined: ports absent, no extra logic.

Test Plan:
- 4x4 board, row options counts 1,2,2,1 (row0 1111; row1 0110,1001) then line_end each, board_done -> base={0,1,3,5}, count={1,2,2,1}, board_loaded=1 two cycles after board_done.
- rd_req rd_line=1 at T -> mem_addr 1,2 at T+1,T+2; opt_valid with 0110 at T+2, 1001 at T+3; opt_last and rd_done at T+3.
- Line closed by line_end with no options, then rd_req on it -> rd_done at T+1, opt_valid never asserted.
- write_ready and line_end in the same cycle -> option counted in the closing line, next option goes to line_idx+1.
- Write 1025 options, ADDR_W=10 -> 1025th dropped, overflow=1 and stays set; clear -> overflow=0, state LOAD.
- Assert rst low mid-DRAIN -> all outputs 0 immediately; rd_req after release is ignored until a new board_done.
